// File: rtl/return_address_stack.sv
// Circular return-address stack for the fetch stage: calls push, returns pop.
// Top-of-stack, valid and overflow are all driven straight from registers.
module return_address_stack #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic        valid_o,
  output logic        overflow_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0] PtrMax  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [63:0]     mem_q [DEPTH];
  logic [PtrW-1:0] tp_q, tp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            overflow_q, overflow_d;

  logic            mem_we;
  logic [PtrW-1:0] mem_waddr;
  logic [PtrW-1:0] tp_inc, tp_dec;
  logic            empty, full;

  // Explicit wrap since DEPTH need not be a power of two.
  assign tp_inc = (tp_q == PtrMax) ? '0 : tp_q + PtrW'(1);
  assign tp_dec = (tp_q == '0) ? PtrMax : tp_q - PtrW'(1);

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntFull);

  always_comb begin
    tp_d       = tp_q;
    cnt_d      = cnt_q;
    overflow_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = tp_inc;

    if (flush_i) begin
      tp_d  = '0;
      cnt_d = '0;
    end else if (push_i && pop_i && !empty) begin
      // Return then call in one bundle: replace the top in place.
      mem_we    = 1'b1;
      mem_waddr = tp_q;
    end else if (push_i) begin
      mem_we    = 1'b1;
      mem_waddr = tp_inc;
      tp_d      = tp_inc;
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop_i && !empty) begin
      tp_d  = tp_dec;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      tp_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (mem_we) begin
        mem_q[mem_waddr] <= data_i;
      end
      tp_q       <= tp_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = mem_q[tp_q];
  assign valid_o    = !empty;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Bench for return_address_stack: DEPTH=4 and DEPTH=3 instances share stimulus and
// are compared against a shift-array stack model plus directed constants.
module tb_return_address_stack;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        push;
  logic        pop;
  logic [63:0] data;

  logic [63:0] data4, data3;
  logic        valid4, valid3;
  logic        ovf4, ovf3;

  int checks;
  int errors;

  // Model: stk[k][0] is oldest, stk[k][sz-1] is top.
  int unsigned dep [2];
  logic [63:0] stk [2][8];
  int unsigned sz  [2];
  logic        ovf_m [2];

  return_address_stack #(.DEPTH(4)) dut4 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .push_i     (push),
    .pop_i      (pop),
    .data_i     (data),
    .data_o     (data4),
    .valid_o    (valid4),
    .overflow_o (ovf4)
  );

  return_address_stack #(.DEPTH(3)) dut3 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .push_i     (push),
    .pop_i      (pop),
    .data_i     (data),
    .data_o     (data3),
    .valid_o    (valid3),
    .overflow_o (ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      sz[k]    = 0;
      ovf_m[k] = 1'b0;
    end
  endtask

  task automatic model_update(input logic f, input logic pu, input logic po,
                              input logic [63:0] d);
    for (int k = 0; k < 2; k++) begin
      ovf_m[k] = 1'b0;
      if (f) begin
        sz[k] = 0;
      end else if (pu && po && sz[k] > 0) begin
        stk[k][sz[k]-1] = d;
      end else if (pu) begin
        if (sz[k] == dep[k]) begin
          for (int i = 0; i + 1 < int'(dep[k]); i++) stk[k][i] = stk[k][i+1];
          stk[k][dep[k]-1] = d;
          ovf_m[k] = 1'b1;
        end else begin
          stk[k][sz[k]] = d;
          sz[k]++;
        end
      end else if (po && sz[k] > 0) begin
        sz[k]--;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " valid4"}, 64'(valid4), 64'(sz[0] > 0));
    check({tag, " ovf4"},   64'(ovf4),   64'(ovf_m[0]));
    check({tag, " cnt4"},   64'(dut4.cnt_q), 64'(sz[0]));
    if (sz[0] > 0) check({tag, " data4"}, data4, stk[0][sz[0]-1]);
    check({tag, " valid3"}, 64'(valid3), 64'(sz[1] > 0));
    check({tag, " ovf3"},   64'(ovf3),   64'(ovf_m[1]));
    check({tag, " cnt3"},   64'(dut3.cnt_q), 64'(sz[1]));
    if (sz[1] > 0) check({tag, " data3"}, data3, stk[1][sz[1]-1]);
  endtask

  // Inputs are applied 1 time unit after an edge and outputs sampled 1 unit after the next.
  task automatic step(input string tag, input logic f, input logic pu, input logic po,
                      input logic [63:0] d);
    flush = f;
    push  = pu;
    pop   = po;
    data  = d;
    @(posedge clk);
    #1;
    model_update(f, pu, po, d);
    flush = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, " rst valid4"}, 64'(valid4), 64'd0);
    check({tag, " rst data4"},  data4, 64'd0);
    check({tag, " rst ovf4"},   64'(ovf4), 64'd0);
    check({tag, " rst valid3"}, 64'(valid3), 64'd0);
    check({tag, " rst data3"},  data3, 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    dep[0] = 4;
    dep[1] = 3;
    model_clear();
    rst_n = 1'b0;
    flush = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    data  = '0;

    // Reset / empty
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", 64'(valid4), 64'd0);
    check("reset data",  data4, 64'd0);
    check("reset ovf",   64'(ovf4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("underflow", 1'b0, 1'b0, 1'b1, 64'h0);
    check("underflow data", data4, 64'd0);

    // LIFO order
    step("lifo push", 1'b0, 1'b1, 1'b0, 64'h100);
    step("lifo push", 1'b0, 1'b1, 1'b0, 64'h200);
    step("lifo push", 1'b0, 1'b1, 1'b0, 64'h300);
    check("lifo top", data4, 64'h300);
    step("lifo pop", 1'b0, 1'b0, 1'b1, 64'h0);
    check("lifo pop1", data4, 64'h200);
    step("lifo pop", 1'b0, 1'b0, 1'b1, 64'h0);
    check("lifo pop2", data4, 64'h100);
    step("lifo pop", 1'b0, 1'b0, 1'b1, 64'h0);
    check("lifo empty", 64'(valid4), 64'd0);

    // Overflow wrap
    step("ovf flush", 1'b1, 1'b0, 1'b0, 64'h0);
    for (int i = 1; i <= 5; i++) begin
      step("ovf push", 1'b0, 1'b1, 1'b0, 64'(i * 16));
      check("ovf pulse", 64'(ovf4), 64'(i == 5));
    end
    for (int i = 0; i < 4; i++) begin
      step("ovf pop", 1'b0, 1'b0, 1'b1, 64'h0);
      if (i == 0) check("ovf pulse clr", 64'(ovf4), 64'd0);
      if (i < 3) check("ovf pop data", data4, 64'(64'h40 - 64'(i * 16)));
    end
    check("ovf lost oldest", 64'(valid4), 64'd0);

    // Back-to-back overflow keeps the pulse high
    for (int i = 0; i < 6; i++) step("ovf b2b", 1'b0, 1'b1, 1'b0, 64'(i + 1));
    check("ovf b2b hold", 64'(ovf4), 64'd1);
    step("ovf idle", 1'b0, 1'b0, 1'b0, 64'h0);
    check("ovf idle clr", 64'(ovf4), 64'd0);

    // Simultaneous push+pop
    step("pp flush", 1'b1, 1'b0, 1'b0, 64'h0);
    step("pp push", 1'b0, 1'b1, 1'b0, 64'hA0);
    step("pp push", 1'b0, 1'b1, 1'b0, 64'hB0);
    step("pp both", 1'b0, 1'b1, 1'b1, 64'hC0);
    check("pp top", data4, 64'hC0);
    check("pp cnt", 64'(dut4.cnt_q), 64'd2);
    step("pp pop", 1'b0, 1'b0, 1'b1, 64'h0);
    check("pp under", data4, 64'hA0);
    step("pp flush", 1'b1, 1'b0, 1'b0, 64'h0);
    step("pp empty both", 1'b0, 1'b1, 1'b1, 64'hC0);
    check("pp empty cnt", 64'(dut4.cnt_q), 64'd1);
    check("pp empty top", data4, 64'hC0);

    // Flush priority
    for (int i = 0; i < 3; i++) step("fl push", 1'b0, 1'b1, 1'b0, 64'(i + 64'h70));
    step("fl flush+push", 1'b1, 1'b1, 1'b0, 64'hDD);
    check("fl valid", 64'(valid4), 64'd0);
    check("fl tp", 64'(dut4.tp_q), 64'd0);
    step("fl push", 1'b0, 1'b1, 1'b0, 64'hEE);
    check("fl next", data4, 64'hEE);

    // Non-power-of-two depth
    step("np flush", 1'b1, 1'b0, 1'b0, 64'h0);
    for (int i = 1; i <= 7; i++) step("np push", 1'b0, 1'b1, 1'b0, 64'(i));
    check("np top", data3, 64'd7);
    step("np pop", 1'b0, 1'b0, 1'b1, 64'h0);
    check("np pop1", data3, 64'd6);
    step("np pop", 1'b0, 1'b0, 1'b1, 64'h0);
    check("np pop2", data3, 64'd5);
    step("np pop", 1'b0, 1'b0, 1'b1, 64'h0);
    check("np empty", 64'(valid3), 64'd0);

    // Asynchronous reset mid-operation
    step("ar push", 1'b0, 1'b1, 1'b0, 64'h1234);
    async_reset("ar");
    step("ar after", 1'b0, 1'b1, 1'b0, 64'h5678);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic        f, pu, po;
      logic [63:0] d;
      f  = ($urandom_range(0, 39) == 0);
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 40);
      d  = {$urandom, $urandom};
      step("rand", f, pu, po, d);
      if (n == 1500) async_reset("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/return_address_stack.md
# return_address_stack

Circular return-address stack that serves the fetch stage's `ras` request interface. Calls push, returns pop. It presents the predicted return address for the next return as a registered top-of-stack value with a valid flag. It sits next to the BTB in the front end and is cleared by the controller on a misspredict or exception flush.

## Interface
- `DEPTH`, default 4: number of entries; must be ≥ 2 (not restricted to a power of two).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  discard all entries (misspredict/exception redirect).
- `push_i`  in  1  `ras.is_call`: push `data_i`.
- `pop_i`  in  1  `ras.is_return`: pop top entry.
- `data_i`  in  64  `ras.ra`: return address to push (call PC + 4).
- `data_o`  out  64  current top-of-stack address.
- `valid_o`  out  1  stack non-empty; `data_o` is meaningful.
- `overflow_o`  out  1  single-cycle pulse: a push dropped the oldest entry.

## Operation
- State:
  - `mem_q[DEPTH][64]`
  - top pointer `tp_q` (`$clog2(DEPTH)` bits, range 0..DEPTH-1)
  - occupancy `cnt_q` (`$clog2(DEPTH+1)` bits, range 0..DEPTH)
- Outputs are driven from state only:
  - `data_o = mem_q[tp_q]`
  - `valid_o = (cnt_q != 0)`
  - `overflow_o` is registered.
- Pointer arithmetic is modulo DEPTH and is written explicitly, because DEPTH need not be a power of two:
  - inc: `tp == DEPTH-1 ? 0 : tp+1`
  - dec: `tp == 0 ? DEPTH-1 : tp-1`
- Per-cycle priority: `flush_i` > push&pop > push > pop > idle.
- Flush:
  - `cnt` ← 0, `tp` ← 0.
  - `mem` is left unchanged.
  - Concurrent push/pop are ignored.
  - `overflow_o` ← 0.
- Push only:
  - `tp` ← inc(`tp`), `mem[inc(tp)]` ← `data_i`.
  - If `cnt < DEPTH`: `cnt` ← `cnt`+1.
  - Otherwise `cnt` stays at DEPTH, the oldest entry is overwritten (wrap), and `overflow_o` pulses 1 next cycle.
- Pop only:
  - If `cnt > 0`: `tp` ← dec(`tp`), `cnt` ← `cnt`-1.
  - If `cnt == 0`: no state change (underflow is silently ignored; `valid_o` stays 0).
- Push and pop together (return immediately followed by call in the same bundle):
  - If `cnt > 0`: `mem[tp]` ← `data_i`; `tp` and `cnt` unchanged.
  - If `cnt == 0`: behaves as push only.
- Idle: hold all state; `overflow_o` ← 0.
- Stale entries below the live region are never exposed: `valid_o` gates them.

## Timing
- Reset values (asynchronous, while `rst_ni` = 0):
  - `mem_q` all 0, `tp_q` = 0, `cnt_q` = 0.
  - `data_o` = 0, `valid_o` = 0, `overflow_o` = 0.
- Reset asserted mid-operation clears state immediately, independent of the clock. The first update after deassertion happens at the next rising edge.
- Latency: a push in cycle N makes `data_o = data_i` and `valid_o = 1` in cycle N+1. A pop in cycle N exposes the next-older entry in N+1.
- No combinational path from any input to any output.
- Requests are single-cycle strobes with no handshake; the block accepts one operation per cycle, every cycle.
- `overflow_o` is high for exactly the one cycle after each overflowing push. Back-to-back overflowing pushes keep it high continuously.

## Test plan
- **Reset/empty:** hold `rst_ni` = 0, then release; pop in cycle 1 → `valid_o` = 0, `data_o` = 0, `cnt_q` = 0 throughout.
- **LIFO order (DEPTH = 4):**
  - Push 0x100, 0x200, 0x300 on consecutive cycles → `data_o` = 0x300 next cycle.
  - Then pop ×3 → `data_o` = 0x200, 0x100, then `valid_o` = 0.
- **Overflow wrap (DEPTH = 4):**
  - Push 0x10..0x50 (5 pushes) → `overflow_o` = 1 only in the cycle after the 5th push.
  - Pops then yield 0x50, 0x40, 0x30, 0x20; after the 4th pop `valid_o` = 0 (0x10 is lost).
- **Simultaneous push+pop:**
  - With 0xA0, 0xB0 on the stack, assert push (0xC0) and pop together → `data_o` = 0xC0 and `cnt_q` = 2; one pop → 0xA0.
  - Repeat the simultaneous push+pop on an empty stack → `cnt_q` = 1, `data_o` = 0xC0.
- **Flush priority:**
  - With 3 entries, assert `flush_i` + `push_i` (0xDD) in the same cycle → next cycle `valid_o` = 0 and `tp_q` = 0.
  - Subsequent push 0xEE → `data_o` = 0xEE.
- **Non-power-of-two (DEPTH = 3):** 7 consecutive pushes of 1..7 then 3 pops → `data_o` sequence 7, 6, 5, then `valid_o` = 0; pointer wraps 2→0 without X.
